// File: rtl/shifter_seq.sv
// -----------------------------------------------------------------------------
// shifter_seq -- multi-cycle barrel shifter, one log-shifter stage per clock.
//
// A request (a, b, op) is accepted in IDLE with an in_valid/in_ready
// handshake. The block then spends exactly SHW cycles in SHIFT. In each cycle
// it applies stage k, which shifts or rotates by 2^k when amt[k] is set.
// The result is then presented in DONE until out_valid/out_ready completes.
// Latency does not depend on the amount or the operation.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   request valid
//   in_ready   request can be accepted (IDLE only, low during reset)
//   a          operand to shift
//   b          shift amount; only b[SHW-1:0] is used (amount mod WIDTH)
//   op         000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others invalid
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts result
//   res        shift result (working register)
//   zero       res == 0
//   bad_op     captured op was 101..111; res then equals a
// -----------------------------------------------------------------------------
module shifter_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             bad_op
);

  localparam int KW = $clog2(SHW);
  localparam logic [KW-1:0] LAST_K = KW'(SHW - 1);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [KW-1:0]    k;
  logic [SHW-1:0]   amt;
  logic [2:0]       op_q;
  logic             sign_q;
  logic             bad_q;
  logic [WIDTH-1:0] work;
  logic             accept;
  int unsigned      stage_dist;

  // The amount is taken modulo WIDTH, so the upper bits of b are dropped.
  logic unused_b;
  assign unused_b = ^b[WIDTH-1:SHW];

  // One stage of the log shifter: move w by sh positions according to o.
  function automatic logic [WIDTH-1:0] stage_apply(
    input logic [WIDTH-1:0] w,
    input logic [2:0]       o,
    input logic             sgn,
    input int unsigned      sh
  );
    logic [WIDTH-1:0] fill;
    // SRA fill comes from the sign bit captured at accept time.
    fill = sgn ? ~({WIDTH{1'b1}} >> sh) : '0;
    case (o)
      OP_SLL:  stage_apply = w << sh;
      OP_SRL:  stage_apply = w >> sh;
      OP_SRA:  stage_apply = (w >> sh) | fill;
      OP_ROL:  stage_apply = (w << sh) | (w >> (WIDTH - sh));
      OP_ROR:  stage_apply = (w >> sh) | (w << (WIDTH - sh));
      default: stage_apply = w;   // invalid op: result is the operand
    endcase
  endfunction

  // in_ready is gated by rst because reset parks the FSM in IDLE, yet no
  // request may be taken while reset is held.
  assign in_ready   = (state == IDLE) && !rst;
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign stage_dist = 32'd1 << k;

  assign res    = work;
  assign zero   = (work == '0);
  assign bad_op = bad_q;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values and simulation matches the synthesized registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic.
  // NOTE: state_n gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = SHIFT;
      SHIFT:   if (k == LAST_K) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: capture on accept, then walk the stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work   <= '0;
      amt    <= '0;
      op_q   <= '0;
      sign_q <= 1'b0;
      bad_q  <= 1'b0;
      k      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            work   <= a;
            amt    <= b[SHW-1:0];
            op_q   <= op;
            sign_q <= a[WIDTH-1];
            bad_q  <= (op > OP_ROR);
            k      <= '0;
          end
        end
        SHIFT: begin
          if (amt[k]) work <= stage_apply(work, op_q, sign_q, stage_dist);
          k <= k + 1'b1;
        end
        default: ;   // DONE: result held until the consumer takes it
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_seq.sv
// -----------------------------------------------------------------------------
// tb_shifter_seq -- scoreboard bench for shifter_seq (WIDTH = 32).
// The driver pushes the expected result when it issues a request. An
// independent monitor pops and compares when out_valid rises. The monitor
// also measures accept-to-valid latency and checks that held results stay
// stable.
// -----------------------------------------------------------------------------
module tb_shifter_seq;

  localparam int W   = 32;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [2:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  res;
  logic          zero;
  logic          bad_op;

  int tests = 0;
  int fails = 0;
  int ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         bad;
  } exp_t;

  exp_t exp_q[$];

  shifter_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .zero      (zero),
    .bad_op    (bad_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: amount taken mod W, result built by single-bit steps.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic [2:0] ov);
    exp_t e;
    logic [W-1:0] r;
    int amt;
    amt = int'(bv % W);
    r = av;
    e.bad = (ov > 3'd4);
    if (!e.bad) begin
      for (int i = 0; i < amt; i++) begin
        case (ov)
          3'd0:    r = {r[W-2:0], 1'b0};
          3'd1:    r = {1'b0, r[W-1:1]};
          3'd2:    r = {r[W-1], r[W-1:1]};
          3'd3:    r = {r[W-2:0], r[W-1]};
          default: r = {r[0], r[W-1:1]};
        endcase
      end
    end
    e.res  = r;
    e.zero = (r == '0);
    return e;
  endfunction

  // out_ready driver; the only writer of out_ready.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: latency, result compare and hold stability.
  int           lat_cnt = 0;
  bit           in_flight = 0;
  bit           seen = 0;
  logic [W-1:0] held;

  always @(negedge clk) begin
    if (rst) begin
      in_flight = 0;
      seen      = 0;
    end else begin
      if (in_flight) lat_cnt++;
      if (out_valid) begin
        if (!seen) begin
          seen = 1;
          held = res;
          if (exp_q.size() == 0) begin
            check("spurious_out_valid", out_valid, 1'b0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("res", res, e.res);
            check("zero", zero, e.zero);
            check("bad_op", bad_op, e.bad);
            check("latency", lat_cnt - 1, LAT);
            in_flight = 0;
          end
        end else begin
          check("hold_res", res, held);
        end
        if (out_ready) seen = 0;
      end
      if (in_valid && in_ready) begin
        in_flight = 1;
        lat_cnt   = 0;
      end
    end
  end

  // Issue one request; caller sits at posedge+1.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2:0] ov);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready_timeout", in_ready, 1'b1);
    in_valid = 1'b1;
    a  = av;
    b  = bv;
    op = ov;
    exp_q.push_back(model(av, bv, ov));
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs while busy: they must not affect the result.
    a  = $urandom;
    b  = $urandom;
    op = 3'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", (exp_q.size() == 0) && !out_valid, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] r;
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    op       = '0;
    out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_res", res, '0);
    check("rst_bad_op", bad_op, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_zero", zero, 1'b1);
    check("post_rst_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;

    // Directed cases.
    send(32'd1, 32'd2, 3'b000);
    send(32'd5173, 32'd11, 3'b000);
    send(32'h8000_0000, 32'd4, 3'b010);
    send(32'h8000_0000, 32'd4, 3'b001);
    send(32'h8000_0000, 32'd1, 3'b000);
    send(32'h0000_0001, 32'd1, 3'b100);
    send(32'h8000_0001, 32'd33, 3'b011);
    send(32'd723, 32'd9, 3'b110);
    send(32'hDEAD_BEEF, 32'd0, 3'b011);
    send(32'hDEAD_BEEF, 32'd31, 3'b010);
    drain();

    // Back-pressure: result held for 10 cycles, requests ignored.
    ready_mode = 0;
    @(posedge clk); #1;
    send(32'h1234, 32'd3, 3'b000);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_wait_valid", out_valid, 1'b1);
    r = res;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_res", res, r);
      in_valid = i[0];
      a = $urandom;
      b = $urandom;
    end
    in_valid   = 1'b0;
    ready_mode = 1;
    @(posedge clk); #1;
    check("xfer_out_valid_low", out_valid, 1'b0);
    check("xfer_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    check("single_xfer", out_valid, 1'b0);
    drain();

    // Reset during SHIFT aborts the operation.
    send(32'hFFFF_0000, 32'd5, 3'b001);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("abort_in_ready", in_ready, 1'b0);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_res", res, '0);
    check("abort_zero", zero, 1'b1);
    check("abort_bad_op", bad_op, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_release_ready", in_ready, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("abort_no_stale_valid", out_valid, 1'b0);
    end
    send(32'd3, 32'd7, 3'b000);
    drain();

    // Randomized traffic with random back-pressure.
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      send($urandom, $urandom, 3'($urandom_range(0, 7)));
    end
    ready_mode = 1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
